regfile_scoreboard: RTL and testbench

//  Issue-side controller for the 2R/1W register bank (1-cycle synchronous read, x0 write-ignored).

---
 rtl/regfile_scoreboard_if.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 139 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Issue, operand, writeback and register-bank signals shared by the scoreboard and its neighbours.
// The slave modport is the scoreboard's view; master is the surrounding pipeline's view.
interface regfile_scoreboard_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic        issue_use_rs1;
   logic        issue_use_rs2;
   logic [4:0]  issue_rd;
   logic        issue_wr_rd;

   logic        operand_valid;
   logic        operand_ready;
   logic [31:0] operand_1;
   logic [31:0] operand_2;

   logic        wb_valid;
   logic [4:0]  wb_index;
   logic [31:0] wb_value;
   logic        wb_spurious;

   logic [4:0]  rf_read_index_1;
   logic [4:0]  rf_read_index_2;
   logic [31:0] rf_read1_value;
   logic [31:0] rf_read2_value;
   logic        rf_write_enabled;
   logic [4:0]  rf_write_index;
   logic [31:0] rf_write_value;

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
             issue_rd, issue_wr_rd, operand_ready, wb_valid, wb_index, wb_value,
             rf_read1_value, rf_read2_value,
      output issue_ready, operand_valid, operand_1, operand_2, wb_spurious,
             rf_read_index_1, rf_read_index_2, rf_write_enabled, rf_write_index,
             rf_write_value
   );

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
             issue_rd, issue_wr_rd, operand_ready, wb_valid, wb_index, wb_value,
             rf_read1_value, rf_read2_value,
      input  issue_ready, operand_valid, operand_1, operand_2, wb_spurious,
             rf_read_index_1, rf_read_index_2, rf_write_enabled, rf_write_index,
             rf_write_value
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for a 2R/1W register bank: tracks pending writes, stalls on RAW/WAW,
// bypasses same-edge writebacks and holds operands until execute consumes them.
module regfile_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_scoreboard_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_HOLD} state_e;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   state_e            state_q, state_d;
   logic [31:0]       busy_q, busy_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d, inflight_nowb;
   logic              spur_q;
   logic              use1_q, use2_q, byp1_q, byp2_q;
   logic [31:0]       byp1_val_q, byp2_val_q;
   logic [31:0]       hold1_q, hold2_q;

   logic [31:0]       wb_clr, eff_busy;
   logic              wb_nz, wb_hit, wb_spur;
   logic              hazard, cap_ok, issue_ready, accept, accept_wr;
   logic [31:0]       mux1, mux2;
   logic              op_valid;
   logic [31:0]       op1, op2;

   assign wb_nz   = bus.wb_valid && (bus.wb_index != 5'd0);
   assign wb_hit  = wb_nz &&  busy_q[bus.wb_index];
   assign wb_spur = wb_nz && !busy_q[bus.wb_index];

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      wb_clr = '0;
      if (wb_nz) wb_clr[bus.wb_index] = 1'b1;
   end

   assign eff_busy = busy_q & ~wb_clr;

   assign hazard = (bus.issue_use_rs1 && (bus.issue_rs1 != 5'd0) && eff_busy[bus.issue_rs1])
                || (bus.issue_use_rs2 && (bus.issue_rs2 != 5'd0) && eff_busy[bus.issue_rs2])
                || (bus.issue_wr_rd   && (bus.issue_rd  != 5'd0) && eff_busy[bus.issue_rd]);

   // A writeback retiring this cycle frees its slot for an issue on the same edge.
   assign inflight_nowb = inflight_q - {{(CNT_W-1){1'b0}}, wb_hit};
   assign cap_ok        = inflight_nowb < MAX_CNT;

   assign issue_ready = rst_n && !hazard && cap_ok
                     && ((state_q == ST_IDLE) || bus.operand_ready);
   assign accept      = bus.issue_valid && issue_ready;
   assign accept_wr   = accept && bus.issue_wr_rd && (bus.issue_rd != 5'd0);

   always_comb begin
      busy_d = eff_busy;
      if (accept_wr) busy_d[bus.issue_rd] = 1'b1;
   end

   assign inflight_d = inflight_nowb + {{(CNT_W-1){1'b0}}, accept_wr};

   // The bank returns the pre-write value on the accept edge, so a captured bypass wins.
   assign mux1 = !use1_q ? 32'd0 : (byp1_q ? byp1_val_q : bus.rf_read1_value);
   assign mux2 = !use2_q ? 32'd0 : (byp2_q ? byp2_val_q : bus.rf_read2_value);

   always_comb begin
      state_d  = state_q;
      op_valid = 1'b0;
      op1      = 32'd0;
      op2      = 32'd0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_READ;
         end
         ST_READ: begin
            op_valid = 1'b1;
            op1      = mux1;
            op2      = mux2;
            if (bus.operand_ready) state_d = accept ? ST_READ : ST_IDLE;
            else                   state_d = ST_HOLD;
         end
         ST_HOLD: begin
            op_valid = 1'b1;
            op1      = hold1_q;
            op2      = hold2_q;
            if (bus.operand_ready) state_d = accept ? ST_READ : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= '0;
         inflight_q <= '0;
         spur_q     <= 1'b0;
         use1_q     <= 1'b0;
         use2_q     <= 1'b0;
         byp1_q     <= 1'b0;
         byp2_q     <= 1'b0;
         byp1_val_q <= '0;
         byp2_val_q <= '0;
         hold1_q    <= '0;
         hold2_q    <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
         spur_q     <= wb_spur;
         if (accept) begin
            use1_q     <= bus.issue_use_rs1;
            use2_q     <= bus.issue_use_rs2;
            byp1_q     <= wb_nz && (bus.wb_index == bus.issue_rs1);
            byp2_q     <= wb_nz && (bus.wb_index == bus.issue_rs2);
            byp1_val_q <= bus.wb_value;
            byp2_val_q <= bus.wb_value;
         end
         if ((state_q == ST_READ) && !bus.operand_ready) begin
            hold1_q <= mux1;
            hold2_q <= mux2;
         end
      end
   end

   assign bus.issue_ready      = issue_ready;
   assign bus.operand_valid    = op_valid;
   assign bus.operand_1        = op1;
   assign bus.operand_2        = op2;
   assign bus.wb_spurious      = spur_q;
   assign bus.rf_read_index_1  = bus.issue_rs1;
   assign bus.rf_read_index_2  = bus.issue_rs2;
   assign bus.rf_write_enabled = bus.wb_valid && rst_n;
   assign bus.rf_write_index   = bus.wb_index;
   assign bus.rf_write_value   = bus.wb_value;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a behavioural register bank plus an expected-operand queue
// filled at issue and drained when execute consumes operands.
module tb_regfile_scoreboard;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t exp_q[$];
   logic [31:0] ref_regs [32];

   regfile_scoreboard_if bus ();

   regfile_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 0) ? 32'd0 : (32'hA000_0000 | 32'(i));
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register bank: synchronous read returning the pre-write value, x0 never written.
   initial begin
      logic [31:0] bank [32];
      for (int i = 0; i < 32; i++) bank[i] = init_val(i);
      bus.rf_read1_value = 32'd0;
      bus.rf_read2_value = 32'd0;
      forever begin
         @(posedge clk);
         bus.rf_read1_value <= bank[bus.rf_read_index_1];
         bus.rf_read2_value <= bank[bus.rf_read_index_2];
         if (bus.rf_write_enabled && (bus.rf_write_index != 5'd0))
            bank[bus.rf_write_index] = bus.rf_write_value;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.issue_valid   = 1'b0;
      bus.issue_rs1     = 5'd0;
      bus.issue_rs2     = 5'd0;
      bus.issue_use_rs1 = 1'b0;
      bus.issue_use_rs2 = 1'b0;
      bus.issue_rd      = 5'd0;
      bus.issue_wr_rd   = 1'b0;
      bus.operand_ready = 1'b1;
      bus.wb_valid      = 1'b0;
      bus.wb_index      = 5'd0;
      bus.wb_value      = 32'd0;
   endtask

   task automatic drive_issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic wr);
      bus.issue_valid   = 1'b1;
      bus.issue_rs1     = rs1;
      bus.issue_use_rs1 = u1;
      bus.issue_rs2     = rs2;
      bus.issue_use_rs2 = u2;
      bus.issue_rd      = rd;
      bus.issue_wr_rd   = wr;
   endtask

   task automatic drive_wb(input logic [4:0] idx, input logic [31:0] val);
      bus.wb_valid = 1'b1;
      bus.wb_index = idx;
      bus.wb_value = val;
      if (idx != 5'd0) ref_regs[idx] = val;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back('{op1: a, op2: b});
   endtask

   task automatic check_ops(input string tag, input bit consume);
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         chk({tag, "_valid"}, 32'(bus.operand_valid), 32'd1);
         chk({tag, "_op1"}, bus.operand_1, exp_q[0].op1);
         chk({tag, "_op2"}, bus.operand_2, exp_q[0].op2);
         if (consume) void'(exp_q.pop_front());
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);

      // Reset
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", 32'(bus.issue_ready), 32'd0);
      chk("rst_valid", 32'(bus.operand_valid), 32'd0);
      chk("rst_op1", bus.operand_1, 32'd0);
      chk("rst_spur", 32'(bus.wb_spurious), 32'd0);
      chk("rst_wen", 32'(bus.rf_write_enabled), 32'd0);
      rst_n = 1'b1;
      tick();

      // Plain issue reading x1/x2, writing x3
      drive_issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
      @(negedge clk);
      chk("t1_ready", 32'(bus.issue_ready), 32'd1);
      chk("t1_rdidx", 32'(bus.rf_read_index_2), 32'd2);
      push_exp(ref_regs[1], ref_regs[2]);
      tick();

      // RAW on busy x3 stalls, then a same-cycle writeback releases and bypasses
      idle_inputs();
      drive_issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      check_ops("t1", 1'b1);
      chk("t2_blocked", 32'(bus.issue_ready), 32'd0);
      tick();
      drive_wb(5'd3, 32'h0000_DEAD);
      @(negedge clk);
      chk("t2_ready", 32'(bus.issue_ready), 32'd1);
      chk("t2_wen", 32'(bus.rf_write_enabled), 32'd1);
      push_exp(ref_regs[3], 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_ops("t2_bypass", 1'b1);
      tick();

      // Four back-to-back writes fill the in-flight budget
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(5 + k), 1'b1);
         @(negedge clk);
         if (k > 0) check_ops("t3_b2b", 1'b1);
         chk("t3_b2b_ready", 32'(bus.issue_ready), 32'd1);
         push_exp(32'd0, 32'd0);
         tick();
      end
      idle_inputs();
      drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
      @(negedge clk);
      check_ops("t3_fourth", 1'b1);
      chk("t3_full", 32'(bus.issue_ready), 32'd0);
      tick();
      drive_wb(5'd5, 32'h0000_5555);
      @(negedge clk);
      chk("t3_freed", 32'(bus.issue_ready), 32'd1);
      push_exp(32'd0, 32'd0);
      tick();
      idle_inputs();
      drive_wb(5'd6, 32'h0000_6666);
      @(negedge clk);
      check_ops("t3_fifth", 1'b1);
      tick();

      // Operands held stable while execute stalls
      idle_inputs();
      bus.operand_ready = 1'b0;
      drive_issue(5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      @(negedge clk);
      chk("t4_ready", 32'(bus.issue_ready), 32'd1);
      push_exp(ref_regs[1], ref_regs[5]);
      tick();
      for (int j = 0; j < 3; j++) begin
         idle_inputs();
         bus.operand_ready = 1'b0;
         bus.issue_rs1     = 5'(12 + j);
         bus.issue_rs2     = 5'(20 + j);
         @(negedge clk);
         check_ops("t4_hold", 1'b0);
         tick();
      end
      idle_inputs();
      @(negedge clk);
      check_ops("t4_release", 1'b1);
      tick();

      // Spurious writeback pulses once and leaves the counter alone; x0 never pulses
      idle_inputs();
      drive_wb(5'd9, 32'h0000_9999);
      @(negedge clk);
      chk("t5_spur_pre", 32'(bus.wb_spurious), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("t5_spur", 32'(bus.wb_spurious), 32'd1);
      tick();
      idle_inputs();
      drive_wb(5'd0, 32'h0000_1234);
      @(negedge clk);
      chk("t5_spur_end", 32'(bus.wb_spurious), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("t5_x0_spur", 32'(bus.wb_spurious), 32'd0);
      tick();
      idle_inputs();
      drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
      @(negedge clk);
      chk("t5_cnt_slot", 32'(bus.issue_ready), 32'd1);
      push_exp(32'd0, 32'd0);
      tick();
      idle_inputs();
      drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
      @(negedge clk);
      check_ops("t5_slot", 1'b1);
      chk("t5_cnt_full", 32'(bus.issue_ready), 32'd0);
      tick();

      // Mid-operation reset from HOLD with x3 busy
      idle_inputs();
      bus.operand_ready = 1'b0;
      drive_wb(5'd7, 32'h0000_7777);
      drive_issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
      @(negedge clk);
      chk("t6_ready", 32'(bus.issue_ready), 32'd1);
      push_exp(ref_regs[9], 32'd0);
      tick();
      idle_inputs();
      bus.operand_ready = 1'b0;
      @(negedge clk);
      check_ops("t6_read", 1'b0);
      tick();
      idle_inputs();
      bus.operand_ready = 1'b0;
      @(negedge clk);
      check_ops("t6_hold", 1'b0);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("t6_rst_valid", 32'(bus.operand_valid), 32'd0);
      chk("t6_rst_op1", bus.operand_1, 32'd0);
      chk("t6_rst_ready", 32'(bus.issue_ready), 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      tick();
      idle_inputs();
      drive_issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
      @(negedge clk);
      chk("t6_ready_after", 32'(bus.issue_ready), 32'd1);
      push_exp(ref_regs[3], 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_ops("t6_post", 1'b1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
